// File: rtl/display_pkg.sv
// Shared encodings for the display mode controller: FSM state / status
// values and the derivation of the debounce length in clock cycles.
package display_pkg;

    // State encoding doubles as the status output value.
    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        ST_MID   = 2'd1,
        ST_HIGH  = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    // Number of clk cycles a button must stay stable before it is accepted.
    function automatic int debounce_cyc(input int clk_freq, input int debounce_ms);
        return (clk_freq / 1000) * debounce_ms;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, stable-time debouncer and a
// registered one-cycle press pulse (rising debounced level only).
module btn_debounce
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic             r_deb_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Bring the raw asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Flip the debounced level after DEBOUNCE_CYC consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync2 != r_deb) begin
            if (r_cnt == CNT_LAST) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Registered press pulse on the cycle after the debounced level rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb_d <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_deb_d <= r_deb;
            r_press <= r_deb & ~r_deb_d;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/display_mode_ctrl.sv
// Display mode controller: three debounced buttons drive a LOW/MID/HIGH
// speed FSM with a pause state that remembers the speed it interrupted.
// Optional feature macro: SPEED_WRAP_EN (up in HIGH wraps to LOW and
// down in LOW wraps to HIGH; otherwise both saturate).
module display_mode_ctrl
    import display_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_pause,
    output logic [1:0] status,
    output logic       changed
);

    localparam int DEBOUNCE_CYC = debounce_cyc(CLK_FREQ, DEBOUNCE_MS);

`ifdef SPEED_WRAP_EN
    localparam state_t UP_FROM_HIGH  = ST_LOW;
    localparam state_t DOWN_FROM_LOW = ST_HIGH;
`else
    localparam state_t UP_FROM_HIGH  = ST_HIGH;
    localparam state_t DOWN_FROM_LOW = ST_LOW;
`endif

    logic   w_up_evt;
    logic   w_down_evt;
    logic   w_pause_evt;
    state_t r_state;
    state_t r_saved;
    logic   r_changed;
    state_t w_next;
    state_t w_saved_next;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_up (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_up),
        .o_press (w_up_evt)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_down (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_down),
        .o_press (w_down_evt)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_pause (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_pause),
        .o_press (w_pause_evt)
    );

    // Next-state logic: pause wins, then a lone up or down moves the speed.
    always_comb begin
        w_next       = r_state;
        w_saved_next = r_saved;
        if (w_pause_evt) begin
            if (r_state == ST_PAUSE) begin
                w_next = r_saved;
            end else begin
                w_saved_next = r_state;
                w_next       = ST_PAUSE;
            end
        end else if ((r_state != ST_PAUSE) && (w_up_evt ^ w_down_evt)) begin
            if (w_up_evt) begin
                case (r_state)
                    ST_LOW:  w_next = ST_MID;
                    ST_MID:  w_next = ST_HIGH;
                    ST_HIGH: w_next = UP_FROM_HIGH;
                    default: w_next = r_state;
                endcase
            end else begin
                case (r_state)
                    ST_HIGH: w_next = ST_MID;
                    ST_MID:  w_next = ST_LOW;
                    ST_LOW:  w_next = DOWN_FROM_LOW;
                    default: w_next = r_state;
                endcase
            end
        end
    end

    // State, saved speed and change pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_LOW;
            r_saved   <= ST_LOW;
            r_changed <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_saved   <= w_saved_next;
            r_changed <= (w_next != r_state);
        end
    end

    assign status  = r_state;
    assign changed = r_changed;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Directed bench for display_mode_ctrl with CLK_FREQ=4000, DEBOUNCE_MS=1
// (4-cycle debounce, 8-cycle raw edge to status latency).
module tb_display_mode_ctrl;

    localparam int DEB = 4;
    localparam int LAT = DEB + 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_pause = 1'b0;
    logic [1:0] status;
    logic       changed;

    int n_cmp = 0;
    int n_fail = 0;
    int chg_cnt = 0;
    int base = 0;

    display_mode_ctrl #(.CLK_FREQ(4000), .DEBOUNCE_MS(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_pause (btn_pause),
        .status    (status),
        .changed   (changed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (changed === 1'b1) chg_cnt <= chg_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0:       btn_up = v;
            1:       btn_down = v;
            default: btn_pause = v;
        endcase
    endtask

    // Full press: hold long enough to register, release, let it settle.
    task automatic press(input int which);
        set_btn(which, 1'b1);
        repeat (LAT) tick();
        set_btn(which, 1'b0);
        repeat (LAT) tick();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_status", 32'(status), 0);
        chk("rst_changed", 32'(changed), 0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("post_rst_status", 32'(status), 0);

        // 3-cycle glitch is rejected
        base = chg_cnt;
        btn_up = 1'b1;
        repeat (3) tick();
        btn_up = 1'b0;
        repeat (12) tick();
        chk("glitch_status", 32'(status), 0);
        chk("glitch_changed", 32'(chg_cnt - base), 0);

        // Clean up press held 20 cycles: exact latency, one event
        base = chg_cnt;
        btn_up = 1'b1;
        for (int k = 1; k < LAT; k++) begin
            tick();
            chk($sformatf("lat_before_%0d", k), 32'(status), 0);
        end
        tick();
        chk("lat_update_status", 32'(status), 1);
        chk("lat_update_changed", 32'(changed), 1);
        tick();
        chk("lat_changed_drop", 32'(changed), 0);
        repeat (20 - LAT - 1) tick();
        btn_up = 1'b0;
        repeat (12) tick();
        chk("held_status", 32'(status), 1);
        chk("held_one_event", 32'(chg_cnt - base), 1);

        // Pause / ignored up / resume from MID
        base = chg_cnt;
        press(2);
        chk("pause_enter", 32'(status), 3);
        chk("pause_enter_chg", 32'(chg_cnt - base), 1);
        base = chg_cnt;
        press(0);
        chk("pause_up_ignored", 32'(status), 3);
        chk("pause_up_nochg", 32'(chg_cnt - base), 0);
        base = chg_cnt;
        press(2);
        chk("pause_resume", 32'(status), 1);
        chk("pause_resume_chg", 32'(chg_cnt - base), 1);

        // MID -> HIGH, then up at the top
        press(0);
        chk("to_high", 32'(status), 2);
        base = chg_cnt;
        press(0);
`ifdef SPEED_WRAP_EN
        chk("up_in_high", 32'(status), 0);
        chk("up_in_high_chg", 32'(chg_cnt - base), 1);
        base = chg_cnt;
        press(1);
        chk("down_in_low", 32'(status), 2);
        chk("down_in_low_chg", 32'(chg_cnt - base), 1);
        press(1);
        chk("down_to_mid", 32'(status), 1);
        press(1);
        chk("down_to_low", 32'(status), 0);
`else
        chk("up_in_high", 32'(status), 2);
        chk("up_in_high_chg", 32'(chg_cnt - base), 0);
        press(1);
        chk("down_to_mid", 32'(status), 1);
        press(1);
        chk("down_to_low", 32'(status), 0);
        base = chg_cnt;
        press(1);
        chk("down_in_low", 32'(status), 0);
        chk("down_in_low_chg", 32'(chg_cnt - base), 0);
`endif

        // Simultaneous up and down are ignored
        base = chg_cnt;
        btn_up = 1'b1;
        btn_down = 1'b1;
        repeat (LAT) tick();
        btn_up = 1'b0;
        btn_down = 1'b0;
        repeat (LAT) tick();
        chk("updown_status", 32'(status), 0);
        chk("updown_nochg", 32'(chg_cnt - base), 0);

        // Up and pause together from LOW: pause wins
        btn_up = 1'b1;
        btn_pause = 1'b1;
        repeat (LAT) tick();
        btn_up = 1'b0;
        btn_pause = 1'b0;
        repeat (LAT) tick();
        chk("uppause_status", 32'(status), 3);
        press(2);
        chk("uppause_resume", 32'(status), 0);

        // Reset while paused (saved MID) discards saved state
        press(0);
        chk("mid_again", 32'(status), 1);
        press(2);
        chk("paused_mid", 32'(status), 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_status", 32'(status), 0);
        chk("async_rst_changed", 32'(changed), 0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        press(2);
        chk("pause_after_rst", 32'(status), 3);
        press(2);
        chk("resume_saved_low", 32'(status), 0);

        // Reset mid-debounce with button held through release
        btn_up = 1'b1;
        repeat (5) tick();
        #3;
        rst_n = 1'b0;
        tick();
        chk("middeb_rst_status", 32'(status), 0);
        rst_n = 1'b1;
        base = chg_cnt;
        for (int k = 1; k < LAT; k++) begin
            tick();
            chk($sformatf("heldrst_before_%0d", k), 32'(status), 0);
        end
        tick();
        chk("heldrst_update", 32'(status), 1);
        btn_up = 1'b0;
        repeat (12) tick();
        chk("heldrst_status", 32'(status), 1);
        chk("heldrst_one_event", 32'(chg_cnt - base), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
